// File: rtl/ram_loader_if.sv
// Link-side byte handshakes and RAM maintenance port of the RAM loader.
interface ram_loader_if #(
  parameter int unsigned XLEN = 32
);

  // Byte stream from the link receiver
  logic [7:0]      rx_data_i;
  logic            rx_valid_i;
  logic            rx_ready_o;

  // Response bytes to the link transmitter
  logic [7:0]      tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i;

  // Byte-wide maintenance port of IRAM/DRAM
  logic            ram_rw_sel_o;
  logic [XLEN-1:0] ram_rw_addr_o;
  logic [7:0]      ram_wr_data_o;
  logic [3:0]      ram_wr_byte_en_o;
  logic [7:0]      ram_rd_data_i;

  // Hold request to the core
  logic            busy_o;

  // Controller side
  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, ram_rd_data_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output ram_rw_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
    output busy_o
  );

  // Link and RAM side
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, ram_rd_data_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  ram_rw_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
    input  busy_o
  );

endinterface

// File: rtl/ram_loader.sv
// Host-side RAM access controller: parses CMD/ADDR/LEN frames from a byte
// link and sequences byte writes (download) or byte reads (dump) on the
// IRAM/DRAM maintenance port while holding the core off via busy_o.
module ram_loader #(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  ram_loader_if.master bus
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  localparam logic [7:0] REGION_IRAM = 8'h00;
  localparam logic [7:0] REGION_DRAM = 8'h10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WR_DATA,
    ST_ACK,
    ST_ERR,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_SEND
  } state_t;

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic            is_wr_q;
  logic [XLEN-1:0] addr_q;
  logic [15:0]     rem_q;

  logic            rx_fire_c;
  logic            tx_fire_c;
  logic [15:0]     len_c;

  // IRAM is word-organised (lane follows addr[1:0]); DRAM takes every byte
  // on lane 0; anything else is outside the RAM and the write is dropped.
  function automatic logic [3:0] lane_strobe(input logic [XLEN-1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (a[31:24])
      REGION_IRAM: s = 4'b0001 << a[1:0];
      REGION_DRAM: s = 4'b0001;
      default:     s = 4'b0000;
    endcase
    return s;
  endfunction

  // Handshake qualifiers and the full LEN value once its high byte arrives
  assign rx_fire_c = bus.rx_valid_i && bus.rx_ready_o;
  assign tx_fire_c = bus.tx_valid_o && bus.tx_ready_i;
  assign len_c     = {bus.rx_data_i, rem_q[7:0]};

  // The core is held off exactly while the maintenance port owns the RAM
  assign bus.busy_o = bus.ram_rw_sel_o;

  // Frame parser, write/read sequencer and all registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q              <= ST_IDLE;
      cnt_q                <= 2'd0;
      is_wr_q              <= 1'b0;
      addr_q               <= '0;
      rem_q                <= 16'd0;
      bus.rx_ready_o       <= 1'b0;
      bus.tx_data_o        <= 8'h00;
      bus.tx_valid_o       <= 1'b0;
      bus.ram_rw_sel_o     <= 1'b0;
      bus.ram_rw_addr_o    <= '0;
      bus.ram_wr_data_o    <= 8'h00;
      bus.ram_wr_byte_en_o <= 4'b0000;
    end else begin
      // Write strobe is a single-cycle pulse
      bus.ram_wr_byte_en_o <= 4'b0000;

      unique case (state_q)
        ST_IDLE: begin
          bus.rx_ready_o <= 1'b1;
          if (rx_fire_c) begin
            cnt_q <= 2'd0;
            if (bus.rx_data_i == CMD_WR || bus.rx_data_i == CMD_RD) begin
              is_wr_q          <= (bus.rx_data_i == CMD_WR);
              bus.ram_rw_sel_o <= 1'b1;
              state_q          <= ST_ADDR;
            end else begin
              bus.rx_ready_o <= 1'b0;
              bus.tx_data_o  <= RSP_ERR;
              bus.tx_valid_o <= 1'b1;
              state_q        <= ST_ERR;
            end
          end
        end

        // Four address bytes, least significant first
        ST_ADDR: begin
          if (rx_fire_c) begin
            addr_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data_i;
            if (cnt_q == 2'd3) begin
              cnt_q   <= 2'd0;
              state_q <= ST_LEN;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end

        // Two length bytes, least significant first; dispatch on the second
        ST_LEN: begin
          if (rx_fire_c) begin
            if (cnt_q == 2'd0) begin
              rem_q[7:0] <= bus.rx_data_i;
              cnt_q      <= 2'd1;
            end else begin
              rem_q[15:8] <= bus.rx_data_i;
              cnt_q       <= 2'd0;
              if (is_wr_q) begin
                if (len_c == 16'd0) begin
                  bus.rx_ready_o <= 1'b0;
                  bus.tx_data_o  <= RSP_ACK;
                  bus.tx_valid_o <= 1'b1;
                  state_q        <= ST_ACK;
                end else begin
                  state_q <= ST_WR_DATA;
                end
              end else begin
                if (len_c == 16'd0) begin
                  bus.ram_rw_sel_o <= 1'b0;
                  state_q          <= ST_IDLE;
                end else begin
                  bus.rx_ready_o    <= 1'b0;
                  bus.ram_rw_addr_o <= addr_q;
                  state_q           <= ST_RD_ADDR;
                end
              end
            end
          end
        end

        // One RAM write per accepted data byte, then ACK after the last one
        ST_WR_DATA: begin
          if (rx_fire_c) begin
            bus.ram_wr_data_o    <= bus.rx_data_i;
            bus.ram_rw_addr_o    <= addr_q;
            bus.ram_wr_byte_en_o <= lane_strobe(addr_q);
            addr_q               <= addr_q + XLEN'(1);
            rem_q                <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              bus.rx_ready_o <= 1'b0;
              bus.tx_data_o  <= RSP_ACK;
              bus.tx_valid_o <= 1'b1;
              state_q        <= ST_ACK;
            end
          end
        end

        // Single response byte; ACK also releases the RAM
        ST_ACK, ST_ERR: begin
          if (tx_fire_c) begin
            bus.tx_valid_o   <= 1'b0;
            bus.ram_rw_sel_o <= 1'b0;
            bus.rx_ready_o   <= 1'b1;
            state_q          <= ST_IDLE;
          end
        end

        // Address is on the port this cycle; RAM answers next cycle
        ST_RD_ADDR: begin
          state_q <= ST_RD_WAIT;
        end

        // Capture the read byte into the transmit register
        ST_RD_WAIT: begin
          bus.tx_data_o  <= bus.ram_rd_data_i;
          bus.tx_valid_o <= 1'b1;
          state_q        <= ST_RD_SEND;
        end

        // Hold the byte until the transmitter takes it, then advance
        ST_RD_SEND: begin
          if (tx_fire_c) begin
            bus.tx_valid_o <= 1'b0;
            addr_q         <= addr_q + XLEN'(1);
            rem_q          <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              bus.ram_rw_sel_o <= 1'b0;
              bus.rx_ready_o   <= 1'b1;
              state_q          <= ST_IDLE;
            end else begin
              bus.ram_rw_addr_o <= addr_q + XLEN'(1);
              state_q           <= ST_RD_ADDR;
            end
          end
        end

        default: begin
          bus.rx_ready_o   <= 1'b0;
          bus.tx_valid_o   <= 1'b0;
          bus.ram_rw_sel_o <= 1'b0;
          state_q          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed frames plus randomized frames
// checked every cycle against a frame-level model of expected RAM writes and
// response bytes.
module tb_ram_loader;

  localparam int unsigned XLEN = 32;

  logic clk_i = 1'b0;
  logic rst_n_i;

  always #5 clk_i = ~clk_i;

  ram_loader_if #(.XLEN(XLEN)) bus ();

  ram_loader #(.XLEN(XLEN)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic [3:0]  strb;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural RAM: byte array, read data registered one cycle after address
  logic [7:0] ram_mem [logic [31:0]];
  always @(posedge clk_i) begin
    if (bus.ram_wr_byte_en_o != 4'b0000) ram_mem[bus.ram_rw_addr_o] = bus.ram_wr_data_o;
    bus.ram_rd_data_i <= ram_mem.exists(bus.ram_rw_addr_o) ? ram_mem[bus.ram_rw_addr_o] : 8'h00;
  end

  // Reference model state
  logic [7:0] mdl_mem [logic [31:0]];
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] payload[$];
  logic [7:0] lit[$];

  // Observation logs for literal checks
  logic [3:0]  obs_strb[$];
  logic [31:0] obs_waddr[$];
  logic [7:0]  obs_tx[$];
  logic [31:0] obs_taddr[$];
  int          sel_rises = 0;

  bit          stall5 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [31:0] a);
    if (a[31:24] == 8'h00) return 4'(1 << a[1:0]);
    if (a[31:24] == 8'h10) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 8'h00;
  endfunction

  // Per-cycle compare against the model plus transmitter back-pressure
  logic        p_txv = 1'b0;
  logic        p_txr = 1'b0;
  logic        p_sel = 1'b0;
  logic [7:0]  p_txd = 8'h00;
  logic [31:0] p_addr = 32'h0;
  int          hold = 0;

  always @(negedge clk_i) begin
    logic r;
    wr_t  e;
    logic [7:0] et;
    if (!rst_n_i) begin
      p_txv = 1'b0; p_txr = 1'b0; p_sel = 1'b0; p_txd = 8'h00; hold = 0;
      bus.tx_ready_i = 1'b0;
    end else begin
      if (p_txv && p_txr) begin
        obs_tx.push_back(p_txd);
        obs_taddr.push_back(p_addr);
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got %0h expected no byte", p_txd);
        end else begin
          et = exp_tx.pop_front();
          check("tx_data", 64'(p_txd), 64'(et));
        end
      end else if (p_txv) begin
        check("tx_hold_valid", 64'(bus.tx_valid_o), 64'(1));
        check("tx_hold_data", 64'(bus.tx_data_o), 64'(p_txd));
      end

      if (bus.ram_wr_byte_en_o != 4'b0000) begin
        obs_strb.push_back(bus.ram_wr_byte_en_o);
        obs_waddr.push_back(bus.ram_rw_addr_o);
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_unexpected: got strb %0h addr %0h expected no write",
                   bus.ram_wr_byte_en_o, bus.ram_rw_addr_o);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.ram_rw_addr_o), 64'(e.addr));
          check("wr_data", 64'(bus.ram_wr_data_o), 64'(e.data));
          check("wr_strb", 64'(bus.ram_wr_byte_en_o), 64'(e.strb));
        end
      end

      check("busy_eq_sel", 64'(bus.busy_o), 64'(bus.ram_rw_sel_o));
      if (bus.ram_rw_sel_o && !p_sel) sel_rises++;

      if (stall5) begin
        if (!bus.tx_valid_o) begin r = 1'b0; hold = 0; end
        else if (hold >= 5) begin r = 1'b1; hold = 0; end
        else begin r = 1'b0; hold++; end
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      bus.tx_ready_i = r;

      p_txv  = bus.tx_valid_o;
      p_txd  = bus.tx_data_o;
      p_txr  = r;
      p_sel  = bus.ram_rw_sel_o;
      p_addr = bus.ram_rw_addr_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.rx_ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL rx_accept_timeout: got rx_ready 0 expected 1 within 500 cycles");
    end
    @(negedge clk_i);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] len);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  // Write frame from payload; only the first n_send data bytes are sent
  task automatic do_write(input logic [31:0] a, input int n_send, input bit gaps);
    int len;
    logic [31:0] wa;
    logic [3:0]  s;
    len = payload.size();
    for (int i = 0; i < n_send; i++) begin
      wa = a + 32'(i);
      s  = model_strb(wa);
      if (s != 4'b0000) begin
        exp_wr.push_back(wr_t'{addr: wa, data: payload[i], strb: s});
        mdl_mem[wa] = payload[i];
      end
    end
    if (n_send == len) exp_tx.push_back(8'hA5);
    send_hdr(8'h57, a, 16'(len));
    for (int i = 0; i < n_send; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      send_byte(payload[i]);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int len);
    for (int i = 0; i < len; i++) exp_tx.push_back(model_rd(a + 32'(i)));
    send_hdr(8'h52, a, 16'(len));
  endtask

  task automatic wait_idle();
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      done = (exp_tx.size() == 0) && (exp_wr.size() == 0) &&
             !bus.ram_rw_sel_o && bus.rx_ready_o;
      if (!done) begin
        @(negedge clk_i);
        n++;
      end
    end
    check("frame_done", 64'(done), 64'(1));
  endtask

  task automatic clear_obs();
    obs_strb.delete(); obs_waddr.delete(); obs_tx.delete(); obs_taddr.delete();
    sel_rises = 0;
  endtask

  task automatic check_tx_lit(input string name);
    check({name, "_count"}, 64'(obs_tx.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size() && i < obs_tx.size(); i++)
      check(name, 64'(obs_tx[i]), 64'(lit[i]));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rx_ready"}, 64'(bus.rx_ready_o), 64'(0));
    check({name, "_tx_valid"}, 64'(bus.tx_valid_o), 64'(0));
    check({name, "_tx_data"}, 64'(bus.tx_data_o), 64'(0));
    check({name, "_sel"}, 64'(bus.ram_rw_sel_o), 64'(0));
    check({name, "_busy"}, 64'(bus.busy_o), 64'(0));
    check({name, "_addr"}, 64'(bus.ram_rw_addr_o), 64'(0));
    check({name, "_wdata"}, 64'(bus.ram_wr_data_o), 64'(0));
    check({name, "_strb"}, 64'(bus.ram_wr_byte_en_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    logic [7:0]  c;
    int          op;
    int          len;

    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b0;
    rst_n_i        = 1'b1;
    #2 rst_n_i = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    idle(1);
    check("rx_ready_idle", 64'(bus.rx_ready_o), 64'(1));

    // IRAM download of four bytes, lane strobes walk across the word
    clear_obs();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(32'h0000_0000, 4, 1'b0);
    wait_idle();
    check("iram_strb_count", 64'(obs_strb.size()), 64'(4));
    if (obs_strb.size() == 4) begin
      check("iram_strb0", 64'(obs_strb[0]), 64'(4'b0001));
      check("iram_strb1", 64'(obs_strb[1]), 64'(4'b0010));
      check("iram_strb2", 64'(obs_strb[2]), 64'(4'b0100));
      check("iram_strb3", 64'(obs_strb[3]), 64'(4'b1000));
      check("iram_addr3", 64'(obs_waddr[3]), 64'(32'h3));
    end
    lit = '{8'hA5};
    check_tx_lit("iram_ack");

    clear_obs();
    do_read(32'h0000_0000, 4);
    wait_idle();
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_tx_lit("iram_readback");

    // DRAM download, every byte on lane 0
    clear_obs();
    payload = '{8'hAA, 8'hBB};
    do_write(32'h1000_0003, 2, 1'b0);
    wait_idle();
    check("dram_strb_count", 64'(obs_strb.size()), 64'(2));
    if (obs_strb.size() == 2) begin
      check("dram_strb0", 64'(obs_strb[0]), 64'(4'b0001));
      check("dram_strb1", 64'(obs_strb[1]), 64'(4'b0001));
      check("dram_addr0", 64'(obs_waddr[0]), 64'(32'h1000_0003));
      check("dram_addr1", 64'(obs_waddr[1]), 64'(32'h1000_0004));
    end
    clear_obs();
    do_read(32'h1000_0003, 2);
    wait_idle();
    lit = '{8'hAA, 8'hBB};
    check_tx_lit("dram_readback");

    // Zero-length write and read
    clear_obs();
    payload.delete();
    do_write(32'h0000_0100, 0, 1'b0);
    wait_idle();
    check("len0_wr_strb", 64'(obs_strb.size()), 64'(0));
    lit = '{8'hA5};
    check_tx_lit("len0_wr_ack");
    clear_obs();
    do_read(32'h0000_0000, 0);
    wait_idle();
    idle(2);
    check("len0_rd_tx", 64'(obs_tx.size()), 64'(0));
    check("len0_rd_sel_pulse", 64'(sel_rises), 64'(1));

    // Unknown command
    clear_obs();
    exp_tx.push_back(8'hEE);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) begin
      check("err_sel_low", 64'(bus.ram_rw_sel_o), 64'(0));
      @(negedge clk_i);
    end
    wait_idle();
    lit = '{8'hEE};
    check_tx_lit("err_rsp");
    check("err_no_sel", 64'(sel_rises), 64'(0));
    clear_obs();
    do_read(32'h0000_0000, 1);
    wait_idle();
    lit = '{8'h11};
    check_tx_lit("after_err_cmd");

    // Read with a slow transmitter
    clear_obs();
    stall5 = 1'b1;
    do_read(32'h0000_0001, 3);
    wait_idle();
    stall5 = 1'b0;
    lit = '{8'h22, 8'h33, 8'h44};
    check_tx_lit("stall_read");
    check("stall_addr_count", 64'(obs_taddr.size()), 64'(3));
    if (obs_taddr.size() == 3) begin
      check("stall_addr0", 64'(obs_taddr[0]), 64'(32'h1));
      check("stall_addr1", 64'(obs_taddr[1]), 64'(32'h2));
      check("stall_addr2", 64'(obs_taddr[2]), 64'(32'h3));
    end

    // Reset in the middle of a write frame
    clear_obs();
    payload = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_write(32'h0000_0008, 2, 1'b0);
    idle(3);
    check("abort_writes_done", 64'(exp_wr.size()), 64'(0));
    @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 check_reset_vals("midframe_reset");
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    wait_idle();
    check("abort_no_ack", 64'(obs_tx.size()), 64'(0));
    payload = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    do_write(32'h0000_0008, 4, 1'b0);
    wait_idle();
    clear_obs();
    do_read(32'h0000_0008, 4);
    wait_idle();
    lit = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    check_tx_lit("after_reset_frame");

    // Randomized frames across regions, including the address wrap
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0:       base = 32'h0000_0000;
        1:       base = 32'h1000_0000;
        2:       base = 32'h2000_0000;
        default: base = 32'hFFFF_FFF8;
      endcase
      base = base + 32'($urandom_range(0, 15));
      len  = int'($urandom_range(0, 8));
      if (op < 4) begin
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
        do_write(base, len, 1'b1);
      end else if (op < 8) begin
        do_read(base, len);
      end else begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
        exp_tx.push_back(8'hEE);
        send_byte(c);
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
